debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-channel debouncer. Filters NUM_CH asynchronous mechanical inputs (buttons, switches) into clean, clock-synchronous levels.
- Adds per-channel rise/fall event pulses and a "changed" summary flag.
- Sits between board I/O pins and control logic (FSMs, counters, LED apps). One instance serves a whole button/switch bank.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a new level (1 ms at 100 MHz); must be >=2.
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- RST_LEVEL, 1'b0, reset value of synchroniser flops and debounced level for all channels.
- LONG_CYCLES, 200000000, long-press threshold in cycles (used only with DEBOUNCE_LONGPRESS_EN).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- deb_in_i  in  NUM_CH  raw asynchronous inputs, one bit per channel.
- deb_out_o  out  NUM_CH  debounced level per channel.
- rise_o  out  NUM_CH  one-cycle pulse when deb_out_o[n] goes 0->1.
- fall_o  out  NUM_CH  one-cycle pulse when deb_out_o[n] goes 1->0.
- changed_o  out  1  OR of rise_o|fall_o; one-cycle pulse.
- long_o  out  NUM_CH  long-press level (only with DEBOUNCE_LONGPRESS_EN).

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Sync flops and deb_out_o become RST_LEVEL.
  - Counters become 0.
  - rise_o, fall_o, changed_o and long_o become 0.
  - Reset mid-count discards the partial count. No rise/fall pulse is generated by reset itself, nor on the first cycle after it.
- Per channel n: deb_in_i[n] passes through a SYNC_STAGES-deep flop chain to give s[n]. No other logic touches deb_in_i.
- Counter cnt[n], width $clog2(DEBOUNCE_CYCLES), per cycle:
  - If s[n]==deb_out_o[n]: cnt[n] <= 0.
  - Else if cnt[n]==DEBOUNCE_CYCLES-1: deb_out_o[n] <= s[n], cnt[n] <= 0, and the matching rise_o[n]/fall_o[n] registers 1 in the same cycle.
  - Else: cnt[n] <= cnt[n]+1.
- Latency: a clean step on deb_in_i[n] held long enough appears on deb_out_o[n] exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the edge that first samples it.
- Glitch rule: any return of s[n] to the current deb_out_o[n] before the count completes restarts the count from 0. A pulse of length <= DEBOUNCE_CYCLES-1 synced cycles never propagates.
- Pulses: rise_o/fall_o are registered and aligned with the deb_out_o transition cycle. They are high for exactly one cycle and are never both high on the same channel.
- changed_o is registered in the same cycle as the pulses. Simultaneous events on several channels give one shared changed_o pulse.
- Channels are fully independent; no arbitration.
- No saturation or wrap: the counter is always cleared at terminal count.

Optional Feature:
- Macro: DEBOUNCE_LONGPRESS_EN.
- Defined:
  - Per-channel hold counter lcnt[n], width $clog2(LONG_CYCLES+1), counts while deb_out_o[n]==1 and saturates at LONG_CYCLES.
  - long_o[n]=1 while lcnt[n]==LONG_CYCLES.
  - lcnt[n] clears on fall_o[n] or reset.
  - long_o[n] drops in the same cycle deb_out_o[n] drops.
- Undefined: long_o port is absent, and no hold counters are synthesised.

Test Plan (sim params NUM_CH=4, DEBOUNCE_CYCLES=16, SYNC_STAGES=2, LONG_CYCLES=64, 10 ns clock):
- Reset check: assert rst_i for 3 cycles with deb_in_i=4'hF, then release. Expect deb_out_o=0 and no pulses during reset; deb_out_o=4'hF exactly 18 cycles after the first post-reset sampling edge, with rise_o=4'hF and changed_o=1 for 1 cycle.
- Glitch rejection: ch0 high for 10 cycles, low, repeated 5 times -> deb_out_o[0] stays 0, no rise_o[0].
- Clean step and release: ch1 rises and holds 40 cycles, then falls and holds 40 cycles. Expect rise_o[1] at +18 cycles and fall_o[1] at +18 cycles after the fall, each 1 cycle wide.
- Bounce then settle: ch2 toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one rise_o[2], 18 cycles after the last toggle.
- Reset mid-count: ch3 high for 10 cycles, then pulse rst_i for 1 cycle while the input stays high. Expect cnt cleared, deb_out_o[3] remains 0 until 18 cycles after reset release, and exactly one rise_o[3].
- DEBOUNCE_LONGPRESS_EN: hold ch0 for 100 cycles -> long_o[0]=1 at 64 cycles after deb_out_o[0] rises; release -> long_o[0]=0 the same cycle fall_o[0] fires.

Source files
------------

// File: rtl/debounce_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel mechanical input debouncer. Each of NUM_CH raw, asynchronous
// inputs is synchronised through a SYNC_STAGES-deep flop chain. Its output
// level only changes after the synchronised input has disagreed with the
// current level for DEBOUNCE_CYCLES consecutive clock cycles. Every accepted
// change raises a one-cycle rise or fall pulse. The changed flag summarises
// the pulses of all channels.
//
// Optional feature (macro DEBOUNCE_LONGPRESS_EN):
//   Adds a per-channel hold counter and the long_o output. long_o[n] is high
//   once deb_out_o[n] has been high for LONG_CYCLES cycles. When the macro is
//   undefined, neither the port nor the counters exist.
//
// Parameters:
//   NUM_CH          number of independent channels (>= 1)
//   DEBOUNCE_CYCLES stable cycles needed to accept a new level (>= 2)
//   SYNC_STAGES     synchroniser depth per channel (>= 2)
//   RST_LEVEL       reset value of synchroniser flops and debounced levels
//   LONG_CYCLES     long-press threshold in cycles (long-press build only)
//
// Ports:
//   clk_i      in   1       system clock, rising edge
//   rst_i      in   1       synchronous reset, active-high
//   deb_in_i   in   NUM_CH  raw asynchronous inputs
//   deb_out_o  out  NUM_CH  debounced level per channel
//   rise_o     out  NUM_CH  one-cycle pulse on a 0->1 change of deb_out_o[n]
//   fall_o     out  NUM_CH  one-cycle pulse on a 1->0 change of deb_out_o[n]
//   changed_o  out  1       one-cycle pulse when any rise_o/fall_o is high
//   long_o     out  NUM_CH  long-press level (DEBOUNCE_LONGPRESS_EN only)
// -----------------------------------------------------------------------------
module debounce_multi #(
    parameter int   NUM_CH          = 4,
    parameter int   DEBOUNCE_CYCLES = 100000,
    parameter int   SYNC_STAGES     = 2,
    parameter logic RST_LEVEL       = 1'b0,
    parameter int   LONG_CYCLES     = 200000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] deb_in_i,
    output logic [NUM_CH-1:0] deb_out_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic              changed_o
`ifdef DEBOUNCE_LONGPRESS_EN
    ,
    output logic [NUM_CH-1:0] long_o
`endif
);

    // Elaboration-time sanity check of the parameter set.
    localparam bit PARAMS_OK = (NUM_CH >= 1) && (DEBOUNCE_CYCLES >= 2) &&
                               (SYNC_STAGES >= 2) && (LONG_CYCLES >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("debounce_multi: illegal parameter combination");
    end

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Synchroniser. Stage 0 is the only flop that sees deb_in_i. The last
    // stage is the synchronised level used by the filter.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                  sync_lvl;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {(SYNC_STAGES * NUM_CH){RST_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], deb_in_i};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Stability filter
    // -------------------------------------------------------------------------
    logic [CW-1:0]     cnt [NUM_CH];
    logic [NUM_CH-1:0] mismatch;   // synchronised input disagrees with output
    logic [NUM_CH-1:0] at_last;    // counter sits at its terminal value
    logic [NUM_CH-1:0] accept;     // new level is accepted on this edge
    logic [NUM_CH-1:0] rise_d;
    logic [NUM_CH-1:0] fall_d;

    always_comb begin
        mismatch = sync_lvl ^ deb_out_o;
        at_last  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            at_last[n] = (cnt[n] == CNT_LAST);
        end
        // The terminal-count edge is the DEBOUNCE_CYCLES-th consecutive
        // disagreeing cycle, so the change is accepted here.
        accept = mismatch & at_last;
        rise_d = accept & sync_lvl;
        fall_d = accept & ~sync_lvl;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_CH; n++) begin
                cnt[n] <= '0;
            end
            deb_out_o <= {NUM_CH{RST_LEVEL}};
            rise_o    <= '0;
            fall_o    <= '0;
            changed_o <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                // Agreement (including a glitch returning to the current
                // level) restarts the count. The terminal count always clears,
                // so the counter never wraps or saturates.
                if (!mismatch[n] || at_last[n]) begin
                    cnt[n] <= '0;
                end else begin
                    cnt[n] <= cnt[n] + 1'b1;
                end
            end
            // Accepting a change means taking the synchronised level, which
            // is the current level inverted on exactly the accepted channels.
            deb_out_o <= deb_out_o ^ accept;
            rise_o    <= rise_d;
            fall_o    <= fall_d;
            changed_o <= |accept;
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    // -------------------------------------------------------------------------
    // Long-press detection
    // -------------------------------------------------------------------------
    localparam int            LW        = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES);

    logic [LW-1:0] lcnt [NUM_CH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_CH; n++) begin
                lcnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                // Clearing on the falling-edge decision (not on the registered
                // fall pulse) makes long_o drop on the same edge as deb_out_o.
                if (fall_d[n]) begin
                    lcnt[n] <= '0;
                end else if (deb_out_o[n] && (lcnt[n] != LONG_LAST)) begin
                    lcnt[n] <= lcnt[n] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        long_o = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            long_o[n] = (lcnt[n] == LONG_LAST);
        end
    end
`endif

endmodule
